// File: rtl/control_unit_fsm_if.sv
// rtl/control_unit_fsm_if.sv - instruction handshake and memory strobe bundle for control_unit_fsm
interface control_unit_fsm_if #(
  parameter int REG_ADDR_W = 3,
  parameter int OPCODE_W   = 4
) ();
  localparam int INSTR_W = OPCODE_W + 2 * REG_ADDR_W;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;

  modport master (
    output instr, instr_valid, mem_ready,
    input  instr_ready, mem_read, mem_write
  );

  modport slave (
    input  instr, instr_valid, mem_ready,
    output instr_ready, mem_read, mem_write
  );
endinterface

// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - multi-cycle instruction decode/sequencing FSM driving datapath selects and strobes
module control_unit_fsm #(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8,
  parameter int OPCODE_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset_global,
  control_unit_fsm_if.slave          bus,
  input  logic                       zero_flag,
  output logic [REG_ADDR_W-1:0]      reg_a_select,
  output logic [REG_ADDR_W-1:0]      reg_b_select,
  output logic [2**REG_ADDR_W-1:0]   write_enable,
  output logic [3:0]                 g_select,
  output logic [1:0]                 mb_select,
  output logic                       mf_select,
  output logic                       md_select,
  output logic                       load,
  output logic [DATA_W-1:0]          set_value,
  output logic [DATA_W-1:0]          constant_in,
  output logic                       reset_individual,
  output logic                       reset_all,
  output logic                       busy,
  output logic                       illegal_op
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int INSTR_W  = OPCODE_W + 2 * REG_ADDR_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_WB       = 3'd4;

  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_MUL2  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_DIV2  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_CLR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_RST   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_OUT   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(13);

  logic [2:0]            state;
  logic [INSTR_W-1:0]    ir;
  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] field_a;
  logic [REG_ADDR_W-1:0] field_b;
  logic [NUM_REGS-1:0]   one_hot_a;
  logic                  is_write_op;
  logic                  is_mem_op;

  // Every decode below works off the captured word, never the live bus.
  assign opcode      = ir[INSTR_W-1 -: OPCODE_W];
  assign field_a     = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign field_b     = ir[REG_ADDR_W-1:0];
  assign one_hot_a   = NUM_REGS'(1) << field_a;
  assign is_write_op = (opcode <= OP_DIV2) || (opcode == OP_MOV);
  assign is_mem_op   = (opcode == OP_LOAD) || (opcode == OP_STORE);

  always_ff @(posedge clk) begin
    if (!reset_global) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= S_DECODE;
          end
        end
        S_DECODE:   state <= S_EXEC;
        S_EXEC:     state <= is_mem_op ? S_MEM_WAIT : S_IDLE;
        S_MEM_WAIT: begin
          if (bus.mem_ready) state <= (opcode == OP_LOAD) ? S_WB : S_IDLE;
        end
        S_WB:       state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.instr_ready  = (state == S_IDLE);
    busy             = (state != S_IDLE);
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    reg_a_select     = '0;
    reg_b_select     = '0;
    write_enable     = '0;
    g_select         = 4'd0;
    mb_select        = 2'b00;
    mf_select        = 1'b0;
    md_select        = 1'b0;
    load             = 1'b0;
    set_value        = '0;
    constant_in      = '0;
    reset_individual = 1'b0;
    reset_all        = 1'b0;
    illegal_op       = 1'b0;

    // Datapath selects are held for the whole instruction so EXEC/WB see settled buses.
    if (state != S_IDLE) begin
      reg_a_select = field_a;
      reg_b_select = field_b;
      constant_in  = DATA_W'(field_b);
      case (opcode)
        OP_ADD, OP_ADDI: g_select = 4'd0;
        OP_SUB, OP_SUBI: g_select = 4'd1;
        OP_MUL2:         g_select = 4'd5;
        OP_DIV2:         g_select = 4'd6;
        default:         g_select = 4'd0;
      endcase
      if ((opcode == OP_ADDI) || (opcode == OP_SUBI)) mb_select = 2'b01;
      if ((opcode == OP_JMP) || (opcode == OP_JZ)) set_value = DATA_W'({field_a, field_b});
    end

    case (state)
      S_EXEC: begin
        if (is_write_op) begin
          write_enable = one_hot_a;
          mf_select    = 1'b1;
          md_select    = 1'b1;
        end else if (opcode == OP_CLR) begin
          write_enable     = one_hot_a;
          reset_individual = 1'b1;
        end else if (opcode == OP_RST) begin
          reset_all = 1'b1;
        end else if (opcode == OP_JMP) begin
          load = 1'b1;
        end else if (opcode == OP_JZ) begin
          load = zero_flag;
        end else if (opcode == OP_OUT) begin
          mf_select = 1'b1;
          md_select = 1'b1;
        end else if (opcode > OP_JZ) begin
          illegal_op = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        bus.mem_read  = (opcode == OP_LOAD);
        bus.mem_write = (opcode == OP_STORE);
      end
      S_WB: write_enable = one_hot_a;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - scoreboard bench for control_unit_fsm
module tb_control_unit_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_global;
  logic zero_flag;

  control_unit_fsm_if #(.REG_ADDR_W(3), .OPCODE_W(4)) bus ();
  control_unit_fsm_if #(.REG_ADDR_W(4), .OPCODE_W(4)) bus2 ();

  logic [2:0]  reg_a_select, reg_b_select;
  logic [7:0]  write_enable;
  logic [3:0]  g_select;
  logic [1:0]  mb_select;
  logic        mf_select, md_select, load;
  logic [7:0]  set_value, constant_in;
  logic        reset_individual, reset_all, busy, illegal_op;

  logic [3:0]  reg_a_select2, reg_b_select2;
  logic [15:0] write_enable2;
  logic [3:0]  g_select2;
  logic [1:0]  mb_select2;
  logic        mf_select2, md_select2, load2;
  logic [15:0] set_value2, constant_in2;
  logic        reset_individual2, reset_all2, busy2, illegal_op2;

  control_unit_fsm #(.REG_ADDR_W(3), .DATA_W(8), .OPCODE_W(4)) dut (
    .clk(clk), .reset_global(reset_global), .bus(bus), .zero_flag(zero_flag),
    .reg_a_select(reg_a_select), .reg_b_select(reg_b_select), .write_enable(write_enable),
    .g_select(g_select), .mb_select(mb_select), .mf_select(mf_select), .md_select(md_select),
    .load(load), .set_value(set_value), .constant_in(constant_in),
    .reset_individual(reset_individual), .reset_all(reset_all), .busy(busy), .illegal_op(illegal_op)
  );

  control_unit_fsm #(.REG_ADDR_W(4), .DATA_W(16), .OPCODE_W(4)) dut2 (
    .clk(clk), .reset_global(reset_global), .bus(bus2), .zero_flag(1'b0),
    .reg_a_select(reg_a_select2), .reg_b_select(reg_b_select2), .write_enable(write_enable2),
    .g_select(g_select2), .mb_select(mb_select2), .mf_select(mf_select2), .md_select(md_select2),
    .load(load2), .set_value(set_value2), .constant_in(constant_in2),
    .reset_individual(reset_individual2), .reset_all(reset_all2), .busy(busy2), .illegal_op(illegal_op2)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  we;
    logic [3:0]  g;
    logic [1:0]  mb;
    logic        mf, md, ld;
    logic [7:0]  sv;
    logic        ri, ra, ill, mr, mw;
    logic [2:0]  asel, bsel;
    logic [7:0]  k;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ready, busy, chkq;
  } st_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] we;
    logic        mf, md;
  } exp2_t;

  exp_t  exp_q[$];
  st_t   st_q[$];
  exp2_t exp2_q[$];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic done = 1'b0;
  logic final_chk = 1'b0;
  exp_t  act, e_m;
  st_t   s_m;
  exp2_t act2, e2_m;
  logic  quiet;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected strobe records whenever the DUT raises any strobe.
  always @(negedge clk) begin
    if ((|write_enable | bus.mem_read | bus.mem_write | load | reset_individual | reset_all | illegal_op) === 1'b1) begin
      act = '{cyc: cyc, we: write_enable, g: g_select, mb: mb_select, mf: mf_select, md: md_select,
              ld: load, sv: set_value, ri: reset_individual, ra: reset_all, ill: illegal_op,
              mr: bus.mem_read, mw: bus.mem_write, asel: reg_a_select, bsel: reg_b_select, k: constant_in};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: got %h required none", act);
      end else begin
        e_m = exp_q.pop_front();
        if (act !== e_m) begin
          n_bad++;
          $display("FAIL strobe_at_cycle_%0d: got %h required %h", e_m.cyc, act, e_m);
        end
      end
    end
    while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
      s_m = st_q.pop_front();
      quiet = (g_select == 0) && (mb_select == 0) && !mf_select && !md_select && (set_value == 0) &&
              (constant_in == 0) && (reg_a_select == 0) && (reg_b_select == 0) && (write_enable == 0);
      n_vec++;
      if (s_m.cyc != cyc || bus.instr_ready !== s_m.ready || busy !== s_m.busy || (s_m.chkq && quiet !== 1'b1)) begin
        n_bad++;
        $display("FAIL status_at_cycle_%0d: got cyc=%0d ready=%b busy=%b quiet=%b required ready=%b busy=%b",
                 s_m.cyc, cyc, bus.instr_ready, busy, quiet, s_m.ready, s_m.busy);
      end
    end
    if ((|write_enable2) === 1'b1) begin
      act2 = '{cyc: cyc, we: write_enable2, mf: mf_select2, md: md_select2};
      n_vec++;
      if (exp2_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe_wide: got %h required none", act2);
      end else begin
        e2_m = exp2_q.pop_front();
        if (act2 !== e2_m) begin
          n_bad++;
          $display("FAIL wide_mov: got %h required %h", act2, e2_m);
        end
      end
    end
    if (done && !final_chk) begin
      final_chk = 1'b1;
      n_vec++;
      if (exp_q.size() + st_q.size() + exp2_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover_expectations: got %0d pending required 0", exp_q.size() + st_q.size() + exp2_q.size());
      end
    end
  end

  task automatic push_status(input logic r, input logic b, input logic q);
    st_t s;
    s = '{cyc: cyc, ready: r, busy: b, chkq: q};
    st_q.push_back(s);
  endtask

  function automatic exp_t base(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    e = '0;
    e.asel = a;
    e.bsel = b;
    e.k    = {5'd0, b};
    case (op)
      4'd1, 4'd3: e.g = 4'd1;
      4'd4:       e.g = 4'd5;
      4'd5:       e.g = 4'd6;
      default:    e.g = 4'd0;
    endcase
    if (op == 4'd2 || op == 4'd3) e.mb = 2'b01;
    if (op == 4'd9 || op == 4'd13) e.sv = {2'b00, a, b};
    return e;
  endfunction

  task automatic run(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                     input logic zf, input int waits);
    int   c;
    exp_t e;
    logic [7:0] oh;
    c  = cyc;
    oh = 8'd1 << a;
    zero_flag       = zf;
    bus.instr       = {op, a, b};
    bus.instr_valid = 1'b1;
    e = base(op, a, b);
    e.cyc = c + 2;
    if (op <= 4'd5 || op == 4'd8) begin
      e.we = oh; e.mf = 1'b1; e.md = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd6) begin
      e.we = oh; e.ri = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd7) begin
      e.ra = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd9 || (op == 4'd13 && zf)) begin
      e.ld = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd11 || op == 4'd12) begin
      for (int k = 0; k <= waits; k++) begin
        e = base(op, a, b);
        e.cyc = c + 3 + k; e.mr = (op == 4'd11); e.mw = (op == 4'd12);
        exp_q.push_back(e);
      end
      if (op == 4'd11) begin
        e = base(op, a, b);
        e.cyc = c + 4 + waits; e.we = oh;
        exp_q.push_back(e);
      end
    end else if (op >= 4'd14) begin
      e.ill = 1'b1; exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    push_status(1'b0, 1'b1, 1'b0);
    if (op == 4'd11 || op == 4'd12) begin
      repeat (waits + 2) begin @(posedge clk); #1; end
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      if (op == 4'd11) begin
        push_status(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
      end
    end else begin
      repeat (2) begin @(posedge clk); #1; end
    end
    push_status(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int   c;
    exp_t e;
    exp2_t e2;
    reset_global     = 1'b0;
    zero_flag        = 1'b0;
    bus.instr        = '0;
    bus.instr_valid  = 1'b0;
    bus.mem_ready    = 1'b0;
    bus2.instr       = '0;
    bus2.instr_valid = 1'b0;
    bus2.mem_ready   = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    push_status(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    push_status(1'b1, 1'b0, 1'b1);
    reset_global = 1'b1;
    @(posedge clk); #1;
    push_status(1'b1, 1'b0, 1'b1);

    run(4'd0,  3'd2, 3'd5, 1'b0, 0);
    run(4'd1,  3'd7, 3'd1, 1'b0, 0);
    run(4'd2,  3'd0, 3'd6, 1'b0, 0);
    run(4'd3,  3'd4, 3'd3, 1'b0, 0);
    run(4'd4,  3'd1, 3'd1, 1'b0, 0);
    run(4'd5,  3'd6, 3'd0, 1'b0, 0);
    run(4'd6,  3'd5, 3'd0, 1'b0, 0);
    run(4'd7,  3'd0, 3'd0, 1'b0, 0);
    run(4'd8,  3'd3, 3'd4, 1'b0, 0);
    run(4'd9,  3'd1, 3'd7, 1'b0, 0);
    run(4'd13, 3'd5, 3'd2, 1'b0, 0);
    run(4'd13, 3'd5, 3'd2, 1'b1, 0);
    run(4'd10, 3'd2, 3'd2, 1'b0, 0);
    run(4'd11, 3'd3, 3'd1, 1'b0, 4);
    run(4'd11, 3'd6, 3'd0, 1'b0, 0);
    run(4'd12, 3'd2, 3'd5, 1'b0, 2);
    run(4'd15, 3'd1, 3'd1, 1'b0, 0);
    run(4'd14, 3'd0, 3'd0, 1'b0, 0);

    // STORE aborted by reset while waiting on memory.
    c = cyc;
    bus.instr       = {4'd12, 3'd1, 3'd2};
    bus.instr_valid = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      e = base(4'd12, 3'd1, 3'd2);
      e.cyc = c + k; e.mw = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_global = 1'b0;
    @(posedge clk); #1;
    push_status(1'b1, 1'b0, 1'b1);
    reset_global = 1'b1;
    @(posedge clk); #1;
    push_status(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Wide build: MOV A=13, B=1.
    c = cyc;
    bus2.instr       = {4'd8, 4'd13, 4'd1};
    bus2.instr_valid = 1'b1;
    e2 = '{cyc: c + 2, we: 16'h2000, mf: 1'b1, md: 1'b1};
    exp2_q.push_back(e2);
    @(posedge clk); #1;
    bus2.instr_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    done = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/control_unit_fsm.md
CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 Parameter REG_ADDR_W, default 3: register-select width; NUM_REGS = 2**REG_ADDR_W.
REQ-002 Parameter DATA_W, default 8: datapath, constant and PC width.
REQ-003 Parameter OPCODE_W, default 4: opcode width; INSTR_W = OPCODE_W + 2*REG_ADDR_W.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_global  in  1  synchronous, active-low reset.
REQ-006 instr  in  INSTR_W  instruction word: opcode at the top, then field A, then field B.
REQ-007 instr_valid  in  1  instr is valid this cycle.
REQ-008 instr_ready  out  1  block can accept an instruction this cycle.
REQ-009 mem_ready  in  1  memory has completed the pending read or write.
REQ-010 zero_flag  in  1  ALU zero result, sampled in EXEC.
REQ-011 reg_a_select, reg_b_select  out  REG_ADDR_W  register-file read selects.
REQ-012 write_enable  out  NUM_REGS  one-hot register write strobe.
REQ-013 g_select  out  4  ALU function.
REQ-014 mem_read, mem_write  out  1  memory strobes.
REQ-015 mb_select  out  2  Bus B source select; mf_select, md_select  out  1 each  Bus F and Bus D source selects.
REQ-016 load  out  1  PC load pulse; set_value  out  DATA_W  PC target.
REQ-017 constant_in  out  DATA_W  immediate value.
REQ-018 reset_individual, reset_all  out  1  register clear pulses.
REQ-019 busy  out  1  FSM is not in IDLE; illegal_op  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-020 States: IDLE, DECODE, EXEC, MEM_WAIT, WB. instr_ready = 1 only in IDLE.
REQ-021 Accept: in IDLE, if instr_valid is 1, capture instr into an internal register; next state DECODE.
REQ-022 DECODE: drive reg_a_select = field A and reg_b_select = field B from the captured instr; drive constant_in = field B zero-extended to DATA_W; next state EXEC.
REQ-023 Opcode map:
- 0 ADD, 1 SUB: g_select 0/1; mb_select 00.
- 2 ADDI, 3 SUBI: g_select 0/1; mb_select 01.
- 4 MUL2: g_select 5. 5 DIV2: g_select 6.
- 6 CLR: reset_individual.
- 7 RST: reset_all.
- 8 MOV: mb_select 00.
- 9 JMP: set_value = {field A, field B} zero-extended.
- 10 OUT: no write.
- 11 LOAD: mem_read.
- 12 STORE: mem_write.
- 13 JZ: taken only if zero_flag = 1.
REQ-024 Writing ALU ops (0-5) and MOV (8): in EXEC, pulse write_enable[field A] for exactly one cycle with mf_select = md_select = 1; next state IDLE.
REQ-025 CLR: in EXEC, pulse write_enable[field A] and reset_individual together for one cycle. RST: in EXEC, pulse reset_all for one cycle with write_enable = 0.
REQ-026 JMP: in EXEC, pulse load for one cycle with set_value stable. JZ: same, but load is pulsed only if zero_flag = 1. Next state IDLE.
REQ-027 LOAD/STORE: EXEC goes to MEM_WAIT. mem_read (LOAD) or mem_write (STORE) is held high from MEM_WAIT entry until the cycle mem_ready = 1, inclusive; no timeout.
REQ-028 If mem_ready = 1 on the first MEM_WAIT cycle, the strobe is high for exactly one cycle.
REQ-029 LOAD then goes to WB: one-cycle write_enable[field A] with md_select = 0 (memory to Bus D). STORE returns directly to IDLE.
REQ-030 OUT: EXEC only; write_enable = 0; mf_select = md_select = 1.
REQ-031 Undefined opcodes (14, 15, and any above 13 for wider OPCODE_W): pulse illegal_op in EXEC; all strobes stay 0; next state IDLE.
REQ-032 write_enable, mem_read, mem_write, load, reset_individual, reset_all and illegal_op are 0 in every state and cycle not listed above.
REQ-033 The write_enable index comes from the captured instr, never from a stale select; at most one write_enable bit is high in any cycle.
REQ-034 Latency, accept to strobe: 2 cycles for ALU/MOV/CLR/RST/JMP/JZ/OUT. LOAD write occurs 1 cycle after the mem_ready cycle.
REQ-035 instr_valid is ignored outside IDLE; no instruction is queued.

Reset
REQ-036 reset_global = 0 at a rising edge forces IDLE, from any state including MEM_WAIT.
REQ-037 During and after reset, every output is 0 except instr_ready = 1.
REQ-038 An in-flight instruction is discarded on reset and no strobe issues for it.

Verification
REQ-039 Reset release, then ADD (opcode 0, A = 2, B = 5) -> accepted in IDLE; write_enable = 8'b0000_0100 exactly 2 cycles later, g_select = 0.
REQ-040 LOAD A = 3 with mem_ready held low for 4 cycles -> mem_read high for 5 cycles; then write_enable[3] pulses once with md_select = 0.
REQ-041 JZ target 6'h2A: with zero_flag = 0 -> load stays 0; with zero_flag = 1 -> load pulses once with set_value = 8'h2A.
REQ-042 Opcode 15 -> illegal_op pulses once; all strobes stay 0; instr_ready returns to 1 after 2 cycles.
REQ-043 reset_global pulled low during MEM_WAIT of a STORE -> mem_write drops the next cycle, state is IDLE, no write occurs.
REQ-044 REG_ADDR_W = 4, DATA_W = 16: MOV A = 13, B = 1 -> write_enable = 16'h2000.
